reduce_sum: RTL and testbench

REDUCE_SUM -- requirements
Module: reduce_sum

---
 rtl/reduce_sum_pkg.sv | 36 +++
 rtl/reduce_sum_bank.sv | 42 ++++
 rtl/reduce_sum.sv | 175 +++++++++++++++++
 tb/tb_reduce_sum.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_sum_pkg
//  Description : Shared types and constants for the reduce_sum frame adder:
//                FSM state encoding, data width, default geometry and the
//                helpers that derive bank depth and counter widths.
//  Revision    : 1.0  initial release
// ============================================================================
package reduce_sum_pkg;

    localparam int DATA_W           = 32;
    localparam int DEF_PAR          = 2;
    localparam int DEF_BUFFER_DEPTH = 512;

    // Words held by each lane bank for the default geometry.
    localparam int BANK_DEPTH       = DEF_BUFFER_DEPTH / DEF_PAR;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        REDUCE  = 2'd1,
        COMBINE = 2'd2
    } state_e;

    // Words held by each lane bank for an arbitrary geometry.
    function automatic int bank_depth(input int buffer_depth, input int par);
        return buffer_depth / par;
    endfunction

    // Counter width for a range of v values; never returns zero so that a
    // degenerate single-entry range still gets a legal 1-bit vector.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_sum_bank.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_sum_bank
//  Description : Single-write-port, single-asynchronous-read-port register
//                array holding one lane's share of a frame.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk       in   clock, write on rising edge
//    we_i      in   write enable
//    waddr_i   in   write address
//    wdata_i   in   write data
//    raddr_i   in   read address (combinational read)
//    rdata_o   out  read data
// ============================================================================
module reduce_sum_bank #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are deliberately not reset; every entry is rewritten before
    // it is read in each frame.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/reduce_sum.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_sum
//  Description : Collects BUFFER_DEPTH 32-bit words into PAR interleaved
//                banks, reduces them with PAR lane accumulators in parallel,
//                then adds the lanes and emits the frame sum (mod 2^32).
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   sole clock
//    rst        in   synchronous active-high reset
//    in_data    in   input word
//    in_valid   in   in_data valid this cycle (honoured only while filling)
//    out_data   out  last frame sum, held until the next frame completes
//    out_valid  out  one-cycle pulse marking a new out_data
// ============================================================================
module reduce_sum
    import reduce_sum_pkg::*;
#(
    parameter int PAR          = 2,
    parameter int BUFFER_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam int BANK_D = bank_depth(BUFFER_DEPTH, PAR);
    localparam int LANE_W = clog2_min1(PAR);
    localparam int ADDR_W = clog2_min1(BANK_D);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PAR - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BANK_D - 1);

    state_e              state_q,    state_d;
    // The element write counter is kept split as (lane, address) so that
    // bank selection needs no divider for non-power-of-two PAR.
    logic [LANE_W-1:0]   wr_lane_q,  wr_lane_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic [ADDR_W-1:0]   rd_k_q,     rd_k_d;
    logic [DATA_W-1:0]   acc_q [PAR];
    logic [DATA_W-1:0]   acc_d [PAR];
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    logic [DATA_W-1:0]   w_rd_data [PAR];
    logic [PAR-1:0]      w_wr_en;
    logic                w_frame_done;
    logic [DATA_W-1:0]   w_lane_sum;

    // ------------------------------------------------------------------
    // Lane banks: element i lives in bank (i mod PAR) at address (i div PAR)
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < PAR; j++) begin : g_bank
            assign w_wr_en[j] = (state_q == FILL) && in_valid &&
                                (wr_lane_q == LANE_W'(j));

            reduce_sum_bank #(
                .DEPTH (BANK_D),
                .WIDTH (DATA_W),
                .AW    (ADDR_W)
            ) u_bank (
                .clk     (clk),
                .we_i    (w_wr_en[j]),
                .waddr_i (wr_addr_q),
                .wdata_i (in_data),
                .raddr_i (rd_k_q),
                .rdata_o (w_rd_data[j])
            );
        end
    endgenerate

    assign w_frame_done = (wr_lane_q == LANE_LAST) && (wr_addr_q == ADDR_LAST);

    always_comb begin
        w_lane_sum = '0;
        for (int j = 0; j < PAR; j++) begin
            w_lane_sum = w_lane_sum + acc_q[j];
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wr_lane_d   = wr_lane_q;
        wr_addr_d   = wr_addr_q;
        rd_k_d      = rd_k_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        for (int j = 0; j < PAR; j++) begin
            acc_d[j] = acc_q[j];
        end

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (w_frame_done) begin
                        state_d   = REDUCE;
                        wr_lane_d = '0;
                        wr_addr_d = '0;
                        rd_k_d    = '0;
                        for (int j = 0; j < PAR; j++) begin
                            acc_d[j] = '0;
                        end
                    end else if (wr_lane_q == LANE_LAST) begin
                        wr_lane_d = '0;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end else begin
                        wr_lane_d = wr_lane_q + LANE_W'(1);
                    end
                end
            end

            REDUCE: begin
                for (int j = 0; j < PAR; j++) begin
                    acc_d[j] = acc_q[j] + w_rd_data[j];
                end
                if (rd_k_q == ADDR_LAST) begin
                    state_d = COMBINE;
                    rd_k_d  = '0;
                end else begin
                    rd_k_d  = rd_k_q + ADDR_W'(1);
                end
            end

            COMBINE: begin
                out_data_d  = w_lane_sum;
                out_valid_d = 1'b1;
                state_d     = FILL;
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_lane_q   <= '0;
            wr_addr_q   <= '0;
            rd_k_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int j = 0; j < PAR; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_lane_q   <= wr_lane_d;
            wr_addr_q   <= wr_addr_d;
            rd_k_q      <= rd_k_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int j = 0; j < PAR; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reduce_sum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reduce_sum
//  Description : Self-checking bench for reduce_sum. A behavioural model of
//                word acceptance pushes expected (sum, cycle) pairs to a
//                scoreboard; a monitor pops them on each out_valid pulse.
//                Two extra instances cover PAR=1 and PAR=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reduce_sum;

    localparam int FRAME = 512;
    localparam int BD    = 256;     // FRAME / PAR for the default instance

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_valid_p1;
    logic        in_valid_p4;
    logic [31:0] out_data,  out_data_p1,  out_data_p4;
    logic        out_valid, out_valid_p1, out_valid_p4;

    always #5 clk = ~clk;

    reduce_sum #(.PAR(2), .BUFFER_DEPTH(FRAME)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid));

    reduce_sum #(.PAR(1), .BUFFER_DEPTH(FRAME)) u_p1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_p1),
        .out_data(out_data_p1), .out_valid(out_valid_p1));

    reduce_sum #(.PAR(4), .BUFFER_DEPTH(FRAME)) u_p4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_p4),
        .out_data(out_data_p4), .out_valid(out_valid_p4));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_sum = 32'h0;

    // acceptance model of the default instance
    int          m_cnt  = 0;
    int          m_busy = 0;
    logic [31:0] m_sum  = 32'h0;

    // PAR=1 / PAR=4 expectations
    logic arm_p1 = 1'b0, arm_p4 = 1'b0, got_p1 = 1'b0, got_p4 = 1'b0;
    int   exp_p1 = 0, exp_p4 = 0;

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: out_data=%h at cycle %0d, required no pulse", out_data, cyc);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data) begin
                    errors++;
                    $display("FAIL sum: out_data=%h required %h", out_data, e.data);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL latency: pulse at cycle %0d required %0d", cyc, e.cyc);
                end
                last_sum = e.data;
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid_p1 === 1'b1) begin
            checks++;
            if (!arm_p1 || out_data_p1 !== 32'h200 || cyc !== exp_p1) begin
                errors++;
                $display("FAIL par1_pulse: data=%h cycle=%0d armed=%0b required data=00000200 cycle=%0d", out_data_p1, cyc, arm_p1, exp_p1);
            end
            arm_p1 = 1'b0;
            got_p1 = 1'b1;
        end
        if (out_valid_p4 === 1'b1) begin
            checks++;
            if (!arm_p4 || out_data_p4 !== 32'h200 || cyc !== exp_p4) begin
                errors++;
                $display("FAIL par4_pulse: data=%h cycle=%0d armed=%0b required data=00000200 cycle=%0d", out_data_p4, cyc, arm_p4, exp_p4);
            end
            arm_p4 = 1'b0;
            got_p4 = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    // One clock of stimulus for the default instance, followed by the model
    // update: a completed frame blocks acceptance for BD+1 edges.
    task automatic step(input logic [31:0] d, input logic v);
        exp_t e;
        in_data  = d;
        in_valid = v;
        @(posedge clk);
        #1;
        if (m_busy > 0) begin
            m_busy--;
        end else if (v) begin
            m_sum = m_sum + d;
            m_cnt++;
            if (m_cnt == FRAME) begin
                e.data = m_sum;
                e.cyc  = cyc + BD + 1;
                sb.push_back(e);
                m_busy = BD + 1;
                m_cnt  = 0;
                m_sum  = 32'h0;
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_cnt  = 0;
        m_busy = 0;
        m_sum  = 32'h0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) step(32'h0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d pulses outstanding, required 0", name, sb.size());
            sb.delete();
        end
        repeat (3) step(32'h0, 1'b0);
        checks++;
        if (out_data !== last_sum) begin
            errors++;
            $display("FAIL %s_hold: out_data=%h required %h", name, out_data, last_sum);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_par2: out_valid=%b out_data=%h required 0/00000000", out_valid, out_data);
        end
        checks++;
        if (out_valid_p1 !== 1'b0 || out_data_p1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_par1: out_valid=%b out_data=%h required 0/00000000", out_valid_p1, out_data_p1);
        end
        checks++;
        if (out_valid_p4 !== 1'b0 || out_data_p4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_par4: out_valid=%b out_data=%h required 0/00000000", out_valid_p4, out_data_p4);
        end
        rst = 1'b0;
    endtask

    task automatic test_ones();
        for (int i = 0; i < FRAME; i++) step(32'h1, 1'b1);
        drain("ones");
        checks++;
        if (last_sum !== 32'h200) begin
            errors++;
            $display("FAIL ones_sum: got %h required 00000200", last_sum);
        end
    endtask

    task automatic test_ramp_gaps();
        int d = 0;
        while (d < FRAME) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(32'(d), v);
            if (v) d++;
        end
        drain("ramp");
        checks++;
        if (last_sum !== 32'h0001FF00) begin
            errors++;
            $display("FAIL ramp_sum: got %h required 0001ff00", last_sum);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < FRAME; i++) step(32'hFFFF_FFFF, 1'b1);
        drain("wrap");
        checks++;
        if (last_sum !== 32'hFFFF_FE00) begin
            errors++;
            $display("FAIL wrap_sum: got %h required fffffe00", last_sum);
        end
    endtask

    // in_valid held high throughout; the words offered while the first frame
    // is being reduced carry a distinct value so any leakage shows in the sum.
    task automatic test_back_to_back();
        for (int i = 0; i < FRAME + BD + 1 + FRAME; i++)
            step((i >= FRAME && i < FRAME + BD + 1) ? 32'h100 : 32'h1, 1'b1);
        drain("b2b");
        checks++;
        if (last_sum !== 32'h200) begin
            errors++;
            $display("FAIL b2b_sum: got %h required 00000200", last_sum);
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 300; i++) step(32'h7, 1'b1);
        do_reset();
        for (int i = 0; i < FRAME; i++) step(32'h2, 1'b1);
        drain("abort_fill");
        checks++;
        if (last_sum !== 32'h400) begin
            errors++;
            $display("FAIL abort_fill_sum: got %h required 00000400", last_sum);
        end
        // abort in the middle of the reduction
        for (int i = 0; i < FRAME; i++) step(32'h5, 1'b1);
        repeat (100) step(32'h0, 1'b0);
        do_reset();
        sb.delete();
        repeat (300) step(32'h0, 1'b0);
        for (int i = 0; i < FRAME; i++) step(32'h3, 1'b1);
        drain("abort_reduce");
        checks++;
        if (last_sum !== 32'h600) begin
            errors++;
            $display("FAIL abort_reduce_sum: got %h required 00000600", last_sum);
        end
    endtask

    task automatic test_par_variants();
        in_valid_p1 = 1'b1;
        in_valid_p4 = 1'b1;
        for (int i = 0; i < FRAME; i++) step(32'h1, 1'b0);
        in_valid_p1 = 1'b0;
        in_valid_p4 = 1'b0;
        exp_p1 = cyc + 513;
        exp_p4 = cyc + 129;
        arm_p1 = 1'b1;
        arm_p4 = 1'b1;
        for (int i = 0; i < 700 && !(got_p1 && got_p4); i++) step(32'h0, 1'b0);
        checks++;
        if (!got_p1) begin
            errors++;
            $display("FAIL par1_timeout: pulse seen=%0b required 1", got_p1);
        end
        checks++;
        if (!got_p4) begin
            errors++;
            $display("FAIL par4_timeout: pulse seen=%0b required 1", got_p4);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_data     = 32'h0;
        in_valid    = 1'b0;
        in_valid_p1 = 1'b0;
        in_valid_p4 = 1'b0;
        test_reset();
        test_ones();
        test_ramp_gaps();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_par_variants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
